gb_memory_responder: RTL and testbench
======================================

GB_MEMORY_RESPONDER -- requirements
Module: gb_memory_responder

Interface
REQ-001 SHALL have parameter EXT_TIMEOUT, default 255, the external-cycle abort limit in clocks, range 1..255.
REQ-002 SHALL have parameter WRAM_AW, default 13, the WRAM address width (8 KB).
REQ-003 SHALL have ports: iClock  in  1  clock; iReset  in  1  reset, synchronous, active-high.
REQ-004 SHALL have ports: iCpuAddr  in  16  CPU address; iCpuData  in  8  CPU write data; iCpuWe  in  1  CPU write strobe.
REQ-005 SHALL have ports: oCpuData  out  8  read data to CPU; oCpuWait  out  1  CPU stall request.
REQ-006 SHALL have ports: oBootRomAddr  out  8  boot ROM address; iBootRomData  in  8  boot ROM data, combinational.
REQ-007 SHALL have ports: oExtAddr  out  16; oExtData  out  8; oExtWe  out  1; oExtReq  out  1; iExtAck  in  1; iExtData  in  8. These form the external bus for cartridge, VRAM, OAM and I/O.
REQ-008 SHALL have ports: oIntEnable  out  8  IE register; oBootEn  out  1  boot overlay active; oExtTimeout  out  1  one-cycle abort pulse.

Function
REQ-009 SHALL decode each access as follows:
- BOOT: read 0000-00FF while oBootEn=1.
- WRAM: C000-DFFF, plus echo E000-FDFF mapped to C000-DDFF.
- BOOTREG: FF50.
- HRAM: FF80-FFFE, 127 bytes.
- IE: FFFF.
- EXT: all other addresses, and all writes to 0000-00FF.
REQ-010 SHALL drive oBootRomAddr = iCpuAddr[7:0] continuously.
REQ-011 SHALL, for internal reads, register the selected data into oCpuData at the clock edge; data is visible one cycle after the address is presented; oCpuWait stays 0.
REQ-012 SHALL, for internal writes with iCpuWe=1, update the target at that edge with zero wait states.
REQ-013 SHALL return 0xFF for reads of FF50.
REQ-014 SHALL clear oBootEn permanently (until reset) on a write of any nonzero value to FF50; a write of 0x00 has no effect.
REQ-015 SHALL implement FSM states IDLE, EXT_WAIT and EXT_DONE.
REQ-016 SHALL drive oCpuWait = (IDLE and EXT decode) or EXT_WAIT, combinationally.
REQ-017 SHALL, in IDLE with an EXT decode, go to EXT_WAIT at the edge and latch iCpuAddr, iCpuData and iCpuWe into oExtAddr, oExtData and oExtWe.
REQ-018 SHALL hold oExtReq=1 throughout EXT_WAIT, with oExtAddr, oExtData and oExtWe stable.
REQ-019 SHALL, in EXT_WAIT with iExtAck=1, go to EXT_DONE, deassert oExtReq, and load iExtData into oCpuData (reads only; on writes oCpuData holds).
REQ-020 SHALL keep an 8-bit wait counter, cleared on entry to EXT_WAIT and incremented each EXT_WAIT cycle without ack.
REQ-021 SHALL, when the counter reaches EXT_TIMEOUT without ack, go to EXT_DONE, load oCpuData=0xFF, and pulse oExtTimeout for one cycle.
REQ-022 SHALL give ack priority over timeout when both occur in the same cycle; no oExtTimeout pulse is produced.
REQ-023 SHALL, in EXT_DONE, hold oCpuWait=0 and oExtReq=0 and hold oCpuData, returning to IDLE unconditionally; no new access is decoded in EXT_DONE.
REQ-024 SHALL ignore iCpuWe in EXT_WAIT and EXT_DONE; no internal write occurs in those states.
REQ-025 SHALL map echo reads and writes to the same WRAM cell as the corresponding C000-based address: addr minus 0x2000.

Reset
REQ-026 SHALL, on iReset, set: state IDLE, oCpuData=0x00, oExtReq=0, oExtWe=0, oExtAddr=0x0000, oExtData=0x00, oIntEnable=0x00, oBootEn=1, oExtTimeout=0, wait counter 0.
REQ-027 SHALL, on iReset in EXT_WAIT, abort the external cycle at that edge: oExtReq=0 the next cycle, no timeout pulse.
REQ-028 SHALL NOT clear WRAM and HRAM contents on reset.

Verification
REQ-029 Boot overlay: read 0x0005 with iBootRomData=0x31 -> oCpuData=0x31 next cycle. Then write 0x01 to FF50 -> oBootEn=0. Then read 0x0005 -> EXT cycle with oExtAddr=0x0005.
REQ-030 WRAM and echo: write 0xA5 to C123, then read E123 -> oCpuData=0xA5 one cycle later, oCpuWait never asserted.
REQ-031 External read: read 0x4000, ack after 3 cycles with iExtData=0x7E -> oCpuWait high 4 cycles, oExtReq high 3 cycles, oCpuData=0x7E in EXT_DONE.
REQ-032 Timeout: EXT_TIMEOUT=4, read 0x8000, no ack -> EXT_DONE after 4 EXT_WAIT cycles, oCpuData=0xFF, one oExtTimeout pulse. Repeat with ack on the 4th cycle -> data returned, no pulse.
REQ-033 HRAM and IE: write 0x1F to FFFF and 0x42 to FF80 -> oIntEnable=0x1F; reads return 0x1F and 0x42. Write 0x00 to FF50 -> oBootEn stays 1.
REQ-034 Reset mid-cycle: assert iReset in EXT_WAIT -> IDLE next cycle, oExtReq=0, oBootEn=1, oIntEnable=0x00, HRAM data retained.

Source files
------------

// File: rtl/gb_memory_responder.sv
// Game Boy CPU memory responder: decodes each CPU access into boot ROM,
// WRAM (with echo), HRAM, IE, the boot-disable register, or an external
// bus cycle. Internal targets answer with zero wait states. External
// targets stall the CPU until acknowledged or until the wait limit expires.
module gb_memory_responder #(
  parameter int EXT_TIMEOUT = 255,
  parameter int WRAM_AW     = 13
) (
  input  logic        iClock,
  input  logic        iReset,
  input  logic [15:0] iCpuAddr,
  input  logic [7:0]  iCpuData,
  input  logic        iCpuWe,
  output logic [7:0]  oCpuData,
  output logic        oCpuWait,
  output logic [7:0]  oBootRomAddr,
  input  logic [7:0]  iBootRomData,
  output logic [15:0] oExtAddr,
  output logic [7:0]  oExtData,
  output logic        oExtWe,
  output logic        oExtReq,
  input  logic        iExtAck,
  input  logic [7:0]  iExtData,
  output logic [7:0]  oIntEnable,
  output logic        oBootEn,
  output logic        oExtTimeout
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    EXT_WAIT = 2'd1,
    EXT_DONE = 2'd2
  } state_e;

  localparam logic [7:0] TMO = 8'(EXT_TIMEOUT);

  state_e      state_q, state_d;
  logic [7:0]  cpu_data_q, cpu_data_d;
  logic [15:0] ext_addr_q, ext_addr_d;
  logic [7:0]  ext_data_q, ext_data_d;
  logic        ext_we_q, ext_we_d;
  logic [7:0]  wait_cnt_q, wait_cnt_d;
  logic [7:0]  ie_q, ie_d;
  logic        boot_en_q, boot_en_d;
  logic        ext_timeout_q, ext_timeout_d;

  logic dec_boot, dec_wram, dec_breg, dec_hram, dec_ie, dec_ext;
  logic wram_we, hram_we, cpu_wait;
  logic [7:0] int_rd;

  // Storage without reset: contents survive iReset.
  logic [7:0] wram_mem [2**WRAM_AW];
  logic [7:0] hram_mem [127];

  // Echo space E000-FDFF differs from C000-DDFF only in bit 13, so the low
  // WRAM_AW address bits select the same cell for both windows.
  logic [WRAM_AW-1:0] wram_idx;
  logic [6:0]         hram_idx;
  assign wram_idx = iCpuAddr[WRAM_AW-1:0];
  assign hram_idx = iCpuAddr[6:0];

  assign oBootRomAddr = iCpuAddr[7:0];

  // Address decode; writes to the boot window fall through to the bus.
  always_comb begin
    dec_boot = (iCpuAddr[15:8] == 8'h00) && !iCpuWe && boot_en_q;
    dec_wram = (iCpuAddr >= 16'hC000) && (iCpuAddr <= 16'hFDFF);
    dec_breg = (iCpuAddr == 16'hFF50);
    dec_hram = (iCpuAddr >= 16'hFF80) && (iCpuAddr <= 16'hFFFE);
    dec_ie   = (iCpuAddr == 16'hFFFF);
    dec_ext  = !(dec_boot || dec_wram || dec_breg || dec_hram || dec_ie);
  end

  // Internal read-data mux; FF50 and unmapped internal reads return 0xFF.
  always_comb begin
    int_rd = 8'hFF;
    if (dec_boot)      int_rd = iBootRomData;
    else if (dec_wram) int_rd = wram_mem[wram_idx];
    else if (dec_breg) int_rd = 8'hFF;
    else if (dec_hram) int_rd = hram_mem[hram_idx];
    else if (dec_ie)   int_rd = ie_q;
  end

  // Next-state and output logic for the access FSM.
  always_comb begin
    state_d       = state_q;
    cpu_data_d    = cpu_data_q;
    ext_addr_d    = ext_addr_q;
    ext_data_d    = ext_data_q;
    ext_we_d      = ext_we_q;
    wait_cnt_d    = wait_cnt_q;
    ie_d          = ie_q;
    boot_en_d     = boot_en_q;
    ext_timeout_d = 1'b0;
    wram_we       = 1'b0;
    hram_we       = 1'b0;
    cpu_wait      = 1'b0;
    case (state_q)
      IDLE: begin
        if (dec_ext) begin
          cpu_wait   = 1'b1;
          state_d    = EXT_WAIT;
          ext_addr_d = iCpuAddr;
          ext_data_d = iCpuData;
          ext_we_d   = iCpuWe;
          wait_cnt_d = 8'd0;
        end else if (iCpuWe) begin
          wram_we = dec_wram;
          hram_we = dec_hram;
          if (dec_ie) ie_d = iCpuData;
          if (dec_breg && (iCpuData != 8'h00)) boot_en_d = 1'b0;
        end else begin
          cpu_data_d = int_rd;
        end
      end
      EXT_WAIT: begin
        cpu_wait = 1'b1;
        if (iExtAck) begin
          // Ack wins over a timeout landing in the same cycle.
          state_d = EXT_DONE;
          if (!ext_we_q) cpu_data_d = iExtData;
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
          if (wait_cnt_q + 8'd1 == TMO) begin
            state_d       = EXT_DONE;
            cpu_data_d    = 8'hFF;
            ext_timeout_d = 1'b1;
          end
        end
      end
      EXT_DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and register file update, synchronous reset.
  always_ff @(posedge iClock) begin
    if (iReset) begin
      state_q       <= IDLE;
      cpu_data_q    <= 8'h00;
      ext_addr_q    <= 16'h0000;
      ext_data_q    <= 8'h00;
      ext_we_q      <= 1'b0;
      wait_cnt_q    <= 8'd0;
      ie_q          <= 8'h00;
      boot_en_q     <= 1'b1;
      ext_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cpu_data_q    <= cpu_data_d;
      ext_addr_q    <= ext_addr_d;
      ext_data_q    <= ext_data_d;
      ext_we_q      <= ext_we_d;
      wait_cnt_q    <= wait_cnt_d;
      ie_q          <= ie_d;
      boot_en_q     <= boot_en_d;
      ext_timeout_q <= ext_timeout_d;
    end
  end

  // WRAM/HRAM write ports.
  always_ff @(posedge iClock) begin
    if (wram_we) wram_mem[wram_idx] <= iCpuData;
    if (hram_we) hram_mem[hram_idx] <= iCpuData;
  end

  assign oCpuData    = cpu_data_q;
  assign oCpuWait    = cpu_wait;
  assign oExtAddr    = ext_addr_q;
  assign oExtData    = ext_data_q;
  assign oExtWe      = ext_we_q;
  assign oExtReq     = (state_q == EXT_WAIT);
  assign oIntEnable  = ie_q;
  assign oBootEn     = boot_en_q;
  assign oExtTimeout = ext_timeout_q;

endmodule

// File: tb/tb_gb_memory_responder.sv
// Bench for gb_memory_responder: a table of single-cycle internal accesses
// plus hand-written external-cycle, timeout and reset sequences. Expected
// read data is queued when an access is driven and popped when it is due.
module tb_gb_memory_responder;

  logic        iClock, iReset;
  logic [15:0] iCpuAddr;
  logic [7:0]  iCpuData;
  logic        iCpuWe;
  logic [7:0]  oCpuData;
  logic        oCpuWait;
  logic [7:0]  oBootRomAddr;
  logic [7:0]  iBootRomData;
  logic [15:0] oExtAddr;
  logic [7:0]  oExtData;
  logic        oExtWe, oExtReq, iExtAck;
  logic [7:0]  iExtData;
  logic [7:0]  oIntEnable;
  logic        oBootEn, oExtTimeout;

  gb_memory_responder #(.EXT_TIMEOUT(4), .WRAM_AW(13)) dut (
    .iClock(iClock), .iReset(iReset),
    .iCpuAddr(iCpuAddr), .iCpuData(iCpuData), .iCpuWe(iCpuWe),
    .oCpuData(oCpuData), .oCpuWait(oCpuWait),
    .oBootRomAddr(oBootRomAddr), .iBootRomData(iBootRomData),
    .oExtAddr(oExtAddr), .oExtData(oExtData), .oExtWe(oExtWe),
    .oExtReq(oExtReq), .iExtAck(iExtAck), .iExtData(iExtData),
    .oIntEnable(oIntEnable), .oBootEn(oBootEn), .oExtTimeout(oExtTimeout)
  );

  initial iClock = 1'b0;
  always #5 iClock = ~iClock;

  int         n_chk  = 0;
  int         n_fail = 0;
  logic [7:0] sb_q[$];
  logic [7:0] last_data;

  typedef struct {
    logic [15:0] addr;
    logic [7:0]  data;
    logic        we;
    logic [7:0]  boot;
    logic [7:0]  exp;
  } vec_t;

  vec_t vt[16];

  task automatic chk(input string nm, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  // One zero-wait internal access; oCpuData is checked after the next edge.
  task automatic int_access(input logic [15:0] a, input logic [7:0] d, input logic we,
                            input logic [7:0] bd, input logic [7:0] exp_rd, input string nm);
    logic [7:0] e;
    @(negedge iClock);
    iCpuAddr = a; iCpuData = d; iCpuWe = we; iBootRomData = bd;
    #1;
    chk({nm, " wait"}, {15'd0, oCpuWait}, 16'd0);
    chk({nm, " bootaddr"}, {8'd0, oBootRomAddr}, {8'd0, a[7:0]});
    e = we ? last_data : exp_rd;
    sb_q.push_back(e);
    last_data = e;
    @(posedge iClock);
    #1;
    chk({nm, " data"}, {8'd0, oCpuData}, {8'd0, sb_q.pop_front()});
  endtask

  // One external access acknowledged in EXT_WAIT cycle ack_at (0 = never).
  task automatic ext_access(input logic [15:0] a, input logic [7:0] d, input logic we,
                            input int ack_at, input logic [7:0] rd, input int exp_req,
                            input logic exp_to, input logic [7:0] exp_rd, input string nm);
    int req_n, wait_n;
    bit done;
    logic [7:0] e;
    @(negedge iClock);
    iCpuAddr = a; iCpuData = d; iCpuWe = we; iExtAck = 1'b0; iExtData = rd;
    #1;
    chk({nm, " wait idle"}, {15'd0, oCpuWait}, 16'd1);
    e = we ? last_data : exp_rd;
    sb_q.push_back(e);
    req_n = 0; wait_n = 1; done = 0;
    for (int c = 0; c < 300; c++) begin
      @(negedge iClock);
      if (!oExtReq) begin
        done = 1;
        break;
      end
      req_n++;
      if (oCpuWait) wait_n++;
      if (req_n == 1) begin
        chk({nm, " extaddr"}, oExtAddr, a);
        chk({nm, " extwe"}, {15'd0, oExtWe}, {15'd0, we});
        if (we) chk({nm, " extdata"}, {8'd0, oExtData}, {8'd0, d});
      end
      iExtAck = (req_n == ack_at);
    end
    if (!done) begin
      n_chk++; n_fail++;
      $display("FAIL %s bound: oExtReq still %b after 300 cycles, required 0", nm, oExtReq);
    end
    iExtAck = 1'b0;
    chk({nm, " req cycles"}, 16'(req_n), 16'(exp_req));
    chk({nm, " wait cycles"}, 16'(wait_n), 16'(exp_req + 1));
    chk({nm, " done wait"}, {15'd0, oCpuWait}, 16'd0);
    chk({nm, " done data"}, {8'd0, oCpuData}, {8'd0, sb_q.pop_front()});
    chk({nm, " timeout"}, {15'd0, oExtTimeout}, {15'd0, exp_to});
    // Park on FF50 (reads 0xFF) so the following IDLE cycle is harmless.
    iCpuAddr = 16'hFF50; iCpuWe = 1'b0;
    @(negedge iClock);
    chk({nm, " pulse end"}, {15'd0, oExtTimeout}, 16'd0);
    chk({nm, " req idle"}, {15'd0, oExtReq}, 16'd0);
    last_data = 8'hFF;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vt[0]  = '{16'h0005, 8'h00, 1'b0, 8'h31, 8'h31};
    vt[1]  = '{16'hC123, 8'hA5, 1'b1, 8'h00, 8'h00};
    vt[2]  = '{16'hE123, 8'h00, 1'b0, 8'h00, 8'hA5};
    vt[3]  = '{16'hC123, 8'h00, 1'b0, 8'h00, 8'hA5};
    vt[4]  = '{16'hE200, 8'h3C, 1'b1, 8'h00, 8'h00};
    vt[5]  = '{16'hC200, 8'h00, 1'b0, 8'h00, 8'h3C};
    vt[6]  = '{16'hFFFF, 8'h1F, 1'b1, 8'h00, 8'h00};
    vt[7]  = '{16'hFF80, 8'h42, 1'b1, 8'h00, 8'h00};
    vt[8]  = '{16'hFFFF, 8'h00, 1'b0, 8'h00, 8'h1F};
    vt[9]  = '{16'hFF80, 8'h00, 1'b0, 8'h00, 8'h42};
    vt[10] = '{16'hFF50, 8'h00, 1'b1, 8'h00, 8'h00};
    vt[11] = '{16'hFF50, 8'h00, 1'b0, 8'h00, 8'hFF};
    vt[12] = '{16'h00FF, 8'h00, 1'b0, 8'h9A, 8'h9A};
    vt[13] = '{16'hFFFE, 8'h77, 1'b1, 8'h00, 8'h00};
    vt[14] = '{16'hDDFF, 8'h11, 1'b1, 8'h00, 8'h00};
    vt[15] = '{16'hFDFF, 8'h00, 1'b0, 8'h00, 8'h11};

    iReset = 1'b1; iCpuAddr = 16'hFF50; iCpuData = 8'h00; iCpuWe = 1'b0;
    iBootRomData = 8'h00; iExtAck = 1'b0; iExtData = 8'h00;
    repeat (2) @(posedge iClock);
    #1;
    chk("rst cpudata", {8'd0, oCpuData}, 16'h0000);
    chk("rst extreq", {15'd0, oExtReq}, 16'd0);
    chk("rst extwe", {15'd0, oExtWe}, 16'd0);
    chk("rst extaddr", oExtAddr, 16'h0000);
    chk("rst extdata", {8'd0, oExtData}, 16'h0000);
    chk("rst ie", {8'd0, oIntEnable}, 16'h0000);
    chk("rst booten", {15'd0, oBootEn}, 16'd1);
    chk("rst timeout", {15'd0, oExtTimeout}, 16'd0);
    @(negedge iClock);
    iReset = 1'b0;
    last_data = 8'hFF;

    for (int i = 0; i < 16; i++)
      int_access(vt[i].addr, vt[i].data, vt[i].we, vt[i].boot, vt[i].exp,
                 $sformatf("vec%0d", i));
    #1;
    chk("ie value", {8'd0, oIntEnable}, 16'h001F);
    chk("boot after zero write", {15'd0, oBootEn}, 16'd1);

    ext_access(16'h0005, 8'h12, 1'b1, 2, 8'h00, 2, 1'b0, 8'h00, "bootwin write");
    ext_access(16'h4000, 8'h00, 1'b0, 3, 8'h7E, 3, 1'b0, 8'h7E, "ext read");
    ext_access(16'h8000, 8'h00, 1'b0, 0, 8'h00, 4, 1'b1, 8'hFF, "ext timeout");
    ext_access(16'h8000, 8'h00, 1'b0, 4, 8'h5A, 4, 1'b0, 8'h5A, "ack at limit");
    ext_access(16'h9000, 8'h66, 1'b1, 1, 8'hEE, 1, 1'b0, 8'h00, "ext write");

    int_access(16'hFF50, 8'h01, 1'b1, 8'h00, 8'h00, "boot off");
    #1;
    chk("booten cleared", {15'd0, oBootEn}, 16'd0);
    ext_access(16'h0005, 8'h00, 1'b0, 1, 8'hC3, 1, 1'b0, 8'hC3, "boot ext read");

    // Reset in the middle of an external cycle.
    @(negedge iClock);
    iCpuAddr = 16'h4000; iCpuWe = 1'b0; iExtAck = 1'b0;
    repeat (2) @(negedge iClock);
    chk("mid req", {15'd0, oExtReq}, 16'd1);
    iReset = 1'b1; iCpuAddr = 16'hFF80;
    @(posedge iClock);
    #1;
    chk("mid rst req", {15'd0, oExtReq}, 16'd0);
    chk("mid rst wait", {15'd0, oCpuWait}, 16'd0);
    chk("mid rst timeout", {15'd0, oExtTimeout}, 16'd0);
    chk("mid rst booten", {15'd0, oBootEn}, 16'd1);
    chk("mid rst ie", {8'd0, oIntEnable}, 16'h0000);
    chk("mid rst data", {8'd0, oCpuData}, 16'h0000);
    @(negedge iClock);
    iReset = 1'b0;
    last_data = 8'h42;
    int_access(16'hFF80, 8'h00, 1'b0, 8'h00, 8'h42, "hram kept");
    int_access(16'hC123, 8'h00, 1'b0, 8'h00, 8'hA5, "wram kept");
    int_access(16'h0005, 8'h00, 1'b0, 8'h31, 8'h31, "boot back");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
